// File: rtl/counter_run_arbiter_pkg.sv
// Shared types and helpers for the counter run arbiter and its counting engine.
package counter_pkg;

  localparam int CNT_W = 3;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gray mode steps by converting to binary, incrementing, and converting back.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic mode);
    logic [CNT_W-1:0] bin;
    logic [CNT_W-1:0] res;
    bin[CNT_W-1] = cur[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ cur[i];
    end
    if (mode == MODE_BIN) begin
      res = cur + 1'b1;
    end else begin
      bin = bin + 1'b1;
      res = bin ^ (bin >> 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_run_arbiter_if.sv
// Request/grant and counter status bundle between requester logic and the arbiter.
interface counter_run_arbiter_if #(parameter int LEN_W = 4) ();
  import counter_pkg::*;

  logic [1:0]       req;
  logic [1:0]       req_mode;
  logic [LEN_W-1:0] req_len0;
  logic [LEN_W-1:0] req_len1;
  logic [1:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             done_id;

  modport master (
    output req, req_mode, req_len0, req_len1,
    input  grant, busy, count, done, done_id
  );

  modport slave (
    input  req, req_mode, req_len0, req_len1,
    output grant, busy, count, done, done_id
  );

endinterface

// File: rtl/counter_run_arbiter_cnt_step_engine.sv
// 3-bit counting engine: synchronous clear, step enable, binary or Gray sequence.
module cnt_step_engine
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= next_count(count, mode);
    end
  end

endmodule

// File: rtl/counter_run_arbiter.sv
// Round-robin arbiter handing the shared counting engine to one of two requesters per run.
module counter_run_arbiter
  import counter_pkg::*;
#(
  parameter int LEN_W = 4
)
(
  input logic clk,
  input logic reset,
  counter_run_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             ptr, ptr_nxt;
  logic             mode_q, mode_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             done_q, done_nxt;
  logic             done_id_q, done_id_nxt;
  logic             eng_clr, eng_en;
  logic             pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      mode_q    <= MODE_BIN;
      rem       <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      mode_q    <= mode_nxt;
      rem       <= rem_nxt;
      done_q    <= done_nxt;
      done_id_q <= done_id_nxt;
    end
  end

  // An owner dropping its request mid-run aborts immediately, even on the last step.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    mode_nxt    = mode_q;
    rem_nxt     = rem;
    done_nxt    = 1'b0;
    done_id_nxt = done_id_q;
    eng_clr     = 1'b0;
    eng_en      = 1'b0;
    pick        = bus.req[ptr] ? ptr : ~ptr;

    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = RUN;
          owner_nxt = pick;
          mode_nxt  = bus.req_mode[pick];
          rem_nxt   = pick ? bus.req_len1 : bus.req_len0;
          eng_clr   = 1'b1;
        end
      end
      RUN: begin
        if (!bus.req[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = ~owner;
        end else if (rem == '0) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          done_id_nxt = owner;
        end else begin
          eng_en  = 1'b1;
          rem_nxt = rem - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = ~owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  cnt_step_engine u_engine (
    .clk   (clk),
    .reset (reset),
    .clr   (eng_clr),
    .en    (eng_en),
    .mode  (mode_q),
    .count (bus.count)
  );

  assign bus.grant   = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed and random checks of counter_run_arbiter against a run-level reference model.
module tb_counter_run_arbiter;
  import counter_pkg::*;

  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   assertionsEvaluated = 0;
  int   failures = 0;

  counter_run_arbiter_if #(.LEN_W(LEN_W)) bus ();

  counter_run_arbiter #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model tracks a run by elapsed cycles since grant rather than by FSM state.
  bit       mBusy   = 1'b0;
  bit       mOwner  = 1'b0;
  bit       mPtr    = 1'b0;
  bit       mMode   = 1'b0;
  bit       mDoneId = 1'b0;
  int       mLen    = 0;
  int       mE      = 0;
  logic [2:0] mCount = 3'd0;
  int       grayTab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  function automatic logic [2:0] seqVal(input bit mode, input int k);
    if (mode) return 3'(grayTab[k % 8]);
    return 3'(k % 8);
  endfunction

  task automatic modelStep();
    bit o;
    if (reset) begin
      mBusy = 1'b0; mPtr = 1'b0; mCount = 3'd0; mDoneId = 1'b0; mE = 0;
    end else if (!mBusy) begin
      if (|bus.req) begin
        o      = bus.req[mPtr] ? mPtr : ~mPtr;
        mOwner = o;
        mMode  = bus.req_mode[o];
        mLen   = o ? int'(bus.req_len1) : int'(bus.req_len0);
        mE     = 1;
        mBusy  = 1'b1;
        mCount = 3'd0;
      end
    end else if (mE == mLen + 2) begin
      mBusy = 1'b0; mPtr = ~mOwner;
    end else if (!bus.req[mOwner]) begin
      mBusy = 1'b0; mPtr = ~mOwner;
    end else begin
      mE++;
      if (mE <= mLen + 1) mCount = seqVal(mMode, mE - 1);
      else mDoneId = mOwner;
    end
  endtask

  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertionsEvaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] eg;
    logic       ed;
    eg = !mBusy ? 2'b00 : (mOwner ? 2'b10 : 2'b01);
    ed = mBusy && (mE == mLen + 2);
    checkOne("grant",   8'(bus.grant),   8'(eg));
    checkOne("busy",    8'(bus.busy),    8'(mBusy));
    checkOne("done",    8'(bus.done),    8'(ed));
    checkOne("done_id", 8'(bus.done_id), 8'(mDoneId));
    checkOne("count",   8'(bus.count),   8'(mCount));
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] m,
                               input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1);
    bus.req      = r;
    bus.req_mode = m;
    bus.req_len0 = l0;
    bus.req_len1 = l1;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0);
    @(negedge clk);
    runCycles(2);
    reset = 1'b0;
    runCycles(1);

    $display("[TB] binary run len=3 for requester 0");
    applyStimulus(2'b01, 2'b00, 4'd3, 4'd0);
    runCycles(5);
    applyStimulus(2'b00, 2'b00, 4'd3, 4'd0);
    runCycles(2);

    $display("[TB] gray run len=9 for requester 1");
    applyStimulus(2'b10, 2'b10, 4'd0, 4'd9);
    runCycles(11);
    applyStimulus(2'b00, 2'b10, 4'd0, 4'd9);
    runCycles(2);

    $display("[TB] both requesters held, len=2");
    applyStimulus(2'b11, 2'b00, 4'd2, 4'd2);
    runCycles(16);
    applyStimulus(2'b00, 2'b00, 4'd2, 4'd2);
    runCycles(2);

    $display("[TB] zero-length run");
    applyStimulus(2'b01, 2'b00, 4'd0, 4'd0);
    runCycles(2);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
    runCycles(2);

    $display("[TB] abort on third run cycle");
    applyStimulus(2'b01, 2'b00, 4'd7, 4'd1);
    runCycles(3);
    applyStimulus(2'b00, 2'b00, 4'd7, 4'd1);
    runCycles(1);
    applyStimulus(2'b11, 2'b00, 4'd7, 4'd1);
    runCycles(1);
    applyStimulus(2'b10, 2'b00, 4'd7, 4'd1);
    runCycles(3);
    applyStimulus(2'b00, 2'b00, 4'd7, 4'd1);
    runCycles(2);

    $display("[TB] reset in the middle of a run");
    applyStimulus(2'b01, 2'b00, 4'd7, 4'd0);
    runCycles(6);
    reset = 1'b1;
    runCycles(1);
    reset = 1'b0;
    applyStimulus(2'b11, 2'b00, 4'd1, 4'd1);
    runCycles(8);
    applyStimulus(2'b00, 2'b00, 4'd1, 4'd1);
    runCycles(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) bus.req = 2'($urandom_range(3));
      bus.req_mode = 2'($urandom_range(3));
      bus.req_len0 = LEN_W'($urandom_range(15));
      bus.req_len1 = LEN_W'($urandom_range(15));
      reset = ($urandom_range(63) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
    $finish;
  end

endmodule

// File: doc/counter_run_arbiter.md
Name: counter_run_arbiter

Overview:
Shares one 3-bit counting engine between two requesters.
- Each requester asks for a "run": a number of count steps in a chosen sequence mode.
- The block arbitrates round-robin, clears the engine, and steps it the requested number of times.
- It then reports completion with a one-cycle done pulse.
- It sits between requester logic and the 3-bit up/Gray counter datapath; the counter state is exposed on `count`.

Parameters:
- LEN_W, 4, width of requested step count. Maximum run is 2^LEN_W-1 steps.
- CNT_W, 3, counter width. Fixed at 3; not intended to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  2  per-requester run request; level, held until done
- req_mode  in  2  per-requester mode: 0 = binary up, 1 = Gray
- req_len0  in  LEN_W  steps requested by requester 0
- req_len1  in  LEN_W  steps requested by requester 1
- grant  out  2  one-hot owner of the engine; 0 when idle
- busy  out  1  high in RUN and DONE
- count  out  3  counting engine value
- done  out  1  one-cycle pulse at end of a completed run
- done_id  out  1  requester index for the current/last done

Behaviour:
- Reset, applied on any cycle including mid-run:
  - state=IDLE, grant=00, busy=0, done=0, done_id=0, count=000, remaining=0.
  - Round-robin pointer=0, so requester 0 has priority first.
- Sequences, both wrapping:
  - mode 0: 0,1,2,3,4,5,6,7,0...
  - mode 1: 0,1,3,2,6,7,5,4,0...
- IDLE:
  - If any req bit is set, pick an owner:
    - the pointer's requester if it is requesting;
    - otherwise the other requester.
  - Sample the owner's mode and len in that cycle. Later changes to req_mode/req_len* are ignored until the next grant.
  - Next cycle: RUN, grant=onehot(owner), count=000, remaining=len.
  - No req: stay in IDLE; count holds its last value.
- RUN:
  - remaining>0: count advances one step in the latched mode; remaining decrements.
  - remaining==0: next state DONE; count holds.
  - req[owner] low in any RUN cycle (abort): next state IDLE, grant=00, no done pulse, count holds, pointer rotates to the other requester.
- DONE:
  - Exactly one cycle: done=1, done_id=owner, grant still asserted.
  - Next state IDLE; grant=00; pointer = ~owner.
  - req[owner] is ignored in DONE.
- Latency:
  - req sampled at cycle T gives the first RUN cycle at T+1 (count=0).
  - done at T+len+2.
  - len=0: done at T+2 with count=0.
- Back-to-back: at least one IDLE cycle between a DONE and the next grant.
- Simultaneous requests: the pointer decides. Fairness guarantees strict alternation while both requesters hold req.
- Lengths above 8 wrap the sequence. Final count = (len mod 8)-th element of the sequence.
- done is a registered output and never asserts outside DONE.

Decomposition:
- Shared package (counter_pkg):
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - MODE_BIN=1'b0, MODE_GRAY=1'b1;
  - CNT_W.
- Natural sub-module: cnt_step_engine.
  - 3-bit counter with synchronous clear, enable and mode.
  - Next-state logic for both sequences.
- The arbiter FSM, pointer and remaining-length down-counter live in the top.

Test Plan:
- reset, then req=01, mode0=0, len0=3 -> grant=01 from T+1; count 0,1,2,3; done=1, done_id=0 at T+5; grant=00 at T+6.
- req=10, mode1=1, len1=9 -> count walks 0,1,3,2,6,7,5,4,0,1; done at T+11 with count=1, done_id=1.
- req=11 held continuously, both len=2, mode=0 -> grants alternate 01,10,01,...; each done carries matching done_id; one idle cycle between runs.
- req=01, len0=0 -> grant at T+1, done at T+2, count=0.
- req=01, len0=7, drop req[0] at third RUN cycle -> next cycle IDLE, grant=00, no done, count holds 2; a following req=11 grants requester 1.
- reset asserted mid-run (count=5) -> next cycle count=0, grant=00, busy=0, done=0; after release, req=11 grants requester 0 first.
